// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the line-RAM arbiter.
package mem_arb_pkg;

  localparam int unsigned PADDR_W        = 20;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;
  // Byte-offset bits inside one line (4 words x 4 bytes).
  localparam int unsigned LINE_OFF_W     = $clog2(WORDS_PER_LINE * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {IC, DC} req_id_t;

  // Clears the in-line byte offset; requesters' low address bits are don't-care.
  function automatic logic [PADDR_W-1:0] line_base(input logic [PADDR_W-1:0] addr);
    return (addr >> LINE_OFF_W) << LINE_OFF_W;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/ack signals and RAM-side request port of the arbiter.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic               ic_req;
  logic [PADDR_W-1:0] ic_addr;
  logic               ic_ack;
  logic [LINE_W-1:0]  ic_rdata;
  logic               dc_req;
  logic               dc_we;
  logic [PADDR_W-1:0] dc_addr;
  logic [LINE_W-1:0]  dc_wdata;
  logic               dc_ack;
  logic [LINE_W-1:0]  dc_rdata;
  logic [PADDR_W-1:0] data_requested;
  logic [PADDR_W-1:0] where_to_write;
  logic [LINE_W-1:0]  data_to_write;
  logic               write_to_mem;
  logic [LINE_W-1:0]  data_returned;
  logic               busy;

  // Arbiter side.
  modport slave (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, data_returned,
    output ic_ack, ic_rdata, dc_ack, dc_rdata, data_requested, where_to_write,
           data_to_write, write_to_mem, busy
  );

  // Caches plus RAM side.
  modport master (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata, data_returned,
    input  ic_ack, ic_rdata, dc_ack, dc_rdata, data_requested, where_to_write,
           data_to_write, write_to_mem, busy
  );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way I-cache / D-cache grant selection.
// MEM_ARB_DCACHE_PRIO_EN: when defined, the D-cache always wins a conflict;
// otherwise conflicts are resolved round-robin against the last grant.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    ic_req,
  input  logic    dc_req,
  input  logic    grant_en,
  output req_id_t grant
);

`ifdef MEM_ARB_DCACHE_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk, reset, ic_req, grant_en};

  // Fixed priority: any D-cache request wins.
  always_comb begin
    grant = dc_req ? DC : IC;
  end
`else
  req_id_t last_grant_q;

  // Remember who was served last so a conflict goes to the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= IC;
    end else if (grant_en) begin
      last_grant_q <= grant;
    end
  end

  // Single requester wins outright; a conflict goes to the one not served last.
  always_comb begin
    grant = IC;
    if (ic_req && dc_req) begin
      grant = (last_grant_q == IC) ? DC : IC;
    end else if (dc_req) begin
      grant = DC;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Line-RAM arbiter: serves one I-cache or D-cache line transfer at a time with a
// fixed memory latency, returning lines through a one-cycle ack pulse.
// MEM_ARB_DCACHE_PRIO_EN selects fixed D-cache priority in the grant logic.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 5
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  req_id_t            grant_q, grant_d, grant;
  logic               grant_en;
  logic [PADDR_W-1:0] addr_q, addr_d;
  logic               we_q, we_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]  dc_rdata_q, dc_rdata_d;
  logic               ic_ack_q, ic_ack_d;
  logic               dc_ack_q, dc_ack_d;

  mem_arb_rr u_rr (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (bus.ic_req),
    .dc_req   (bus.dc_req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // State and datapath registers; reset abandons any transfer without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      grant_q    <= IC;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_ack_q   <= ic_ack_d;
      dc_ack_q   <= dc_ack_d;
    end
  end

  // Accept in IDLE, count down latency in BUSY, pulse ack once from RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_ack_d   = 1'b0;
    dc_ack_d   = 1'b0;
    grant_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ic_req || bus.dc_req) begin
          grant_en = 1'b1;
          grant_d  = grant;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
          if (grant == IC) begin
            addr_d = line_base(bus.ic_addr);
            we_d   = 1'b0;
          end else begin
            addr_d  = line_base(bus.dc_addr);
            we_d    = bus.dc_we;
            wdata_d = bus.dc_wdata;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Writes leave both rdata registers untouched.
          if (!we_q) begin
            if (grant_q == IC) ic_rdata_d = bus.data_returned;
            else               dc_rdata_d = bus.data_returned;
          end
          if (grant_q == IC) ic_ack_d = 1'b1;
          else               dc_ack_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ic_ack         = ic_ack_q;
  assign bus.dc_ack         = dc_ack_q;
  assign bus.ic_rdata       = ic_rdata_q;
  assign bus.dc_rdata       = dc_rdata_q;
  assign bus.data_requested = addr_q >> 2;
  assign bus.where_to_write = addr_q >> 4;
  assign bus.data_to_write  = wdata_q;
  // Re-writing the same line each BUSY cycle is harmless to the RAM.
  assign bus.write_to_mem   = (state_q == BUSY) && we_q;
  assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences and random pairs
// checked against a transaction-level model of memory, grant order and timing.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if if5 ();
  mem_arbiter_if if1 ();

  mem_arbiter #(.MEM_LATENCY(LAT)) u_dut5 (.clk(clk), .reset(reset), .bus(if5));
  mem_arbiter #(.MEM_LATENCY(1))   u_dut1 (.clk(clk), .reset(reset), .bus(if1));

  // RAM models: 1024 words, sampled on the falling edge.
  logic [31:0] mem5 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] ref_mem [1024];

  always @(negedge clk) begin
    if (if5.write_to_mem)
      for (int i = 0; i < 4; i++)
        mem5[{if5.where_to_write[7:0], 2'(i)}] = if5.data_to_write[32*i +: 32];
    if5.data_returned <= {mem5[{if5.data_requested[9:2], 2'd3}],
                          mem5[{if5.data_requested[9:2], 2'd2}],
                          mem5[{if5.data_requested[9:2], 2'd1}],
                          mem5[{if5.data_requested[9:2], 2'd0}]};
  end

  always @(negedge clk) begin
    if (if1.write_to_mem)
      for (int i = 0; i < 4; i++)
        mem1[{if1.where_to_write[7:0], 2'(i)}] = if1.data_to_write[32*i +: 32];
    if1.data_returned <= {mem1[{if1.data_requested[9:2], 2'd3}],
                          mem1[{if1.data_requested[9:2], 2'd2}],
                          mem1[{if1.data_requested[9:2], 2'd1}],
                          mem1[{if1.data_requested[9:2], 2'd0}]};
  end

  int nvec = 0;
  int nerr = 0;
  req_id_t model_last = IC;
  logic [127:0] exp_ic_rd = '0;
  logic [127:0] exp_dc_rd = '0;

  typedef struct {
    bit           rst;
    bit           ic_v;
    logic [19:0]  ic_a;
    bit           dc_v;
    bit           dc_we;
    logic [19:0]  dc_a;
    logic [127:0] dc_d;
    req_id_t      first;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [31:0] pre(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [127:0] model_line(input logic [19:0] a);
    int base;
    base = int'(a[11:4]) * 4;
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  task automatic model_write(input logic [19:0] a, input logic [127:0] d);
    int base;
    base = int'(a[11:4]) * 4;
    for (int i = 0; i < 4; i++) ref_mem[base+i] = d[32*i +: 32];
  endtask

  function automatic req_id_t predict(input bit ic_v, input bit dc_v);
    if (ic_v && !dc_v) return IC;
    if (dc_v && !ic_v) return DC;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    return DC;
`else
    return (model_last == IC) ? DC : IC;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if5.ic_req = 1'b0;
    if5.dc_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_last = IC;
    exp_ic_rd = '0;
    exp_dc_rd = '0;
  endtask

  // One or two concurrent requests on the latency-5 instance, run to completion.
  task automatic run_pair(input bit ic_v, input logic [19:0] ic_a, input bit dc_v,
                          input bit dc_w, input logic [19:0] dc_a, input logic [127:0] dc_d,
                          input req_id_t first);
    req_id_t order [2];
    int      acc [2];
    int      n;
    bit      e_ica, e_dca, e_wtm, e_busy, is_wr;
    logic [19:0] a;
    n = (ic_v && dc_v) ? 2 : 1;
    order[0] = (n == 2) ? first : (ic_v ? IC : DC);
    order[1] = (order[0] == IC) ? DC : IC;
    acc[0] = 1;
    acc[1] = LAT + 3;
    if5.ic_req = ic_v; if5.ic_addr = ic_a;
    if5.dc_req = dc_v; if5.dc_we = dc_w; if5.dc_addr = dc_a; if5.dc_wdata = dc_d;
    for (int c = 1; c <= acc[n-1] + LAT; c++) begin
      tick();
      e_ica = 0; e_dca = 0; e_wtm = 0; e_busy = 0;
      for (int k = 0; k < n; k++) begin
        is_wr = (order[k] == DC) && dc_w;
        if (c >= acc[k] && c < acc[k] + LAT) e_wtm = e_wtm | is_wr;
        if (c >= acc[k] && c <= acc[k] + LAT) e_busy = 1;
        if (c == acc[k]) begin
          a = (order[k] == IC) ? ic_a : dc_a;
          check("data_requested", if5.data_requested, (a & 20'hFFFF0) >> 2);
          check("where_to_write", if5.where_to_write, a >> 4);
          if (is_wr) check("data_to_write", if5.data_to_write, dc_d);
        end
        if (c == acc[k] + LAT) begin
          if (order[k] == IC) e_ica = 1;
          else e_dca = 1;
        end
      end
      check("ic_ack", if5.ic_ack, e_ica);
      check("dc_ack", if5.dc_ack, e_dca);
      check("write_to_mem", if5.write_to_mem, e_wtm);
      check("busy", if5.busy, e_busy);
      if (e_ica) begin
        exp_ic_rd = model_line(ic_a);
        if5.ic_req = 1'b0;
      end
      if (e_dca) begin
        if (dc_w) model_write(dc_a, dc_d);
        else exp_dc_rd = model_line(dc_a);
        if5.dc_req = 1'b0;
      end
      if (e_ica || e_dca) begin
        check("ic_rdata", if5.ic_rdata, exp_ic_rd);
        check("dc_rdata", if5.dc_rdata, exp_dc_rd);
      end
    end
    tick();
    check("busy_after", if5.busy, 0);
    model_last = order[n-1];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem5[i] = pre(i);
      mem1[i] = pre(i);
      ref_mem[i] = pre(i);
    end
    if5.ic_req = 0; if5.ic_addr = '0; if5.dc_req = 0; if5.dc_we = 0;
    if5.dc_addr = '0; if5.dc_wdata = '0;
    if1.ic_req = 0; if1.ic_addr = '0; if1.dc_req = 0; if1.dc_we = 0;
    if1.dc_addr = '0; if1.dc_wdata = '0;

    vecs[0] = '{1'b0, 1'b1, 20'h00000, 1'b0, 1'b0, 20'h0, 128'h0, IC};
    vecs[1] = '{1'b0, 1'b0, 20'h0, 1'b1, 1'b1, 20'h00400, 128'h4444_3333_2222_1111, DC};
    vecs[2] = '{1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 20'h00400, 128'h0, DC};
    vecs[3] = '{1'b1, 1'b1, 20'h00040, 1'b1, 1'b0, 20'h00100, 128'h0, DC};
    vecs[4] = '{1'b0, 1'b1, 20'h000C5, 1'b1, 1'b1, 20'h00200, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE, DC};
    vecs[5] = '{1'b0, 1'b0, 20'h0, 1'b1, 1'b0, 20'h0020A, 128'h0, DC};
    vecs[6] = '{1'b0, 1'b1, 20'h00200, 1'b1, 1'b0, 20'h00300, 128'h0, IC};
    vecs[7] = '{1'b0, 1'b1, 20'h003F0, 1'b0, 1'b0, 20'h0, 128'h0, IC};
    vecs[8] = '{1'b0, 1'b1, 20'h00400, 1'b1, 1'b1, 20'h00040, 128'h5555_6666_7777_8888, DC};

    // Reset state.
    do_reset();
    check("rst_ic_ack", if5.ic_ack, 0);
    check("rst_dc_ack", if5.dc_ack, 0);
    check("rst_ic_rdata", if5.ic_rdata, 0);
    check("rst_dc_rdata", if5.dc_rdata, 0);
    check("rst_data_requested", if5.data_requested, 0);
    check("rst_where_to_write", if5.where_to_write, 0);
    check("rst_data_to_write", if5.data_to_write, 0);
    check("rst_write_to_mem", if5.write_to_mem, 0);
    check("rst_busy", if5.busy, 0);
    check("rst_busy_l1", if1.busy, 0);

    // Directed table.
    for (int v = 0; v < 9; v++) begin
      req_id_t f;
      if (vecs[v].rst) do_reset();
      f = vecs[v].first;
`ifdef MEM_ARB_DCACHE_PRIO_EN
      if (vecs[v].ic_v && vecs[v].dc_v) f = DC;
`endif
      run_pair(vecs[v].ic_v, vecs[v].ic_a, vecs[v].dc_v, vecs[v].dc_we, vecs[v].dc_a,
               vecs[v].dc_d, f);
    end

    // Back-to-back: I-cache keeps req high across its ack.
    if5.ic_addr = 20'h00040;
    if5.ic_req = 1'b1;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      tick();
      check("b2b_ic_ack", if5.ic_ack, (c == LAT + 1) || (c == 2 * LAT + 3));
      if (c == LAT + 2) check("b2b_idle_gap", if5.busy, 0);
      if (c == LAT + 3) begin
        check("b2b_second_accept", if5.busy, 1);
        check("b2b_second_addr", if5.data_requested, 20'h00030);
      end
      if (c == LAT + 1) begin
        check("b2b_rdata1", if5.ic_rdata, model_line(20'h00040));
        if5.ic_addr = 20'h000C0;
      end
      if (c == 2 * LAT + 3) begin
        exp_ic_rd = model_line(20'h000C0);
        check("b2b_rdata2", if5.ic_rdata, exp_ic_rd);
        if5.ic_req = 1'b0;
      end
    end
    model_last = IC;

    // Reset in the middle of a write: no ack, RAM port idles at once.
    if5.dc_addr = 20'h00800; if5.dc_we = 1'b1;
    if5.dc_wdata = 128'hABCD_0000_1234_5678_9ABC_DEF0_0F0F_F0F0;
    if5.dc_req = 1'b1;
    tick();
    check("mid_rst_wtm_on", if5.write_to_mem, 1);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_wtm_off", if5.write_to_mem, 0);
    check("mid_rst_busy", if5.busy, 0);
    check("mid_rst_dc_rdata", if5.dc_rdata, 0);
    reset = 1'b0;
    if5.dc_req = 1'b0;
    model_write(20'h00800, 128'hABCD_0000_1234_5678_9ABC_DEF0_0F0F_F0F0);
    model_last = IC;
    exp_ic_rd = '0;
    exp_dc_rd = '0;
    for (int c = 0; c < LAT + 3; c++) begin
      tick();
      check("mid_rst_no_ack", {if5.ic_ack, if5.dc_ack}, 0);
    end
    run_pair(1'b0, 20'h0, 1'b1, 1'b0, 20'h00800, 128'h0, DC);

    // Random pairs against the model.
    for (int r = 0; r < 40; r++) begin
      bit ic_v, dc_v, dc_w;
      logic [19:0] ia, da;
      logic [127:0] dd;
      ic_v = 1'($urandom_range(0, 1));
      dc_v = 1'($urandom_range(0, 1));
      if (!ic_v && !dc_v) ic_v = 1'b1;
      dc_w = 1'($urandom_range(0, 1));
      ia = 20'($urandom_range(0, 4095));
      da = 20'($urandom_range(0, 4095));
      dd = {$urandom, $urandom, $urandom, $urandom};
      run_pair(ic_v, ia, dc_v, dc_w, da, dd, predict(ic_v, dc_v));
    end

    // Minimum latency instance.
    if1.ic_addr = 20'h00010;
    if1.ic_req = 1'b1;
    tick();
    check("l1_accept_busy", if1.busy, 1);
    check("l1_no_early_ack", if1.ic_ack, 0);
    tick();
    check("l1_ack", if1.ic_ack, 1);
    check("l1_rdata", if1.ic_rdata, {pre(7), pre(6), pre(5), pre(4)});
    if1.ic_req = 1'b0;
    tick();
    check("l1_ack_once", if1.ic_ack, 0);
    check("l1_idle", if1.busy, 0);
    if1.dc_addr = 20'h00020; if1.dc_we = 1'b1;
    if1.dc_wdata = 128'h1357_9BDF_2468_ACE0_1111_2222_3333_4444;
    if1.dc_req = 1'b1;
    tick();
    check("l1_wtm", if1.write_to_mem, 1);
    tick();
    check("l1_wtm_one_cycle", if1.write_to_mem, 0);
    check("l1_wr_ack", if1.dc_ack, 1);
    if1.dc_req = 1'b0;
    tick();
    if1.dc_we = 1'b0;
    if1.dc_req = 1'b1;
    tick();
    tick();
    check("l1_rd_ack", if1.dc_ack, 1);
    check("l1_rd_data", if1.dc_rdata, 128'h1357_9BDF_2468_ACE0_1111_2222_3333_4444);
    if1.dc_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Upstream neighbour of the 128-bit line RAM; the only master driving the RAM's request port.
- Arbitrates line-read requests from the I-cache against line-read/line-write requests from the D-cache.
- Models fixed memory latency and returns 128-bit lines through a req/ack handshake.

Parameters:
- MEM_LATENCY, 5: cycles from request accept to ack; legal range 1..15.
- PADDR_W, 20: physical byte-address width.
- LINE_W, 128: line width in bits (4 x 32-bit words).

Ports:
- clk  in  1  system clock; RAM samples on negedge, this block on posedge
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  I-cache line-read request
- ic_addr  in  PADDR_W  I-cache line byte address, 16-byte aligned
- ic_ack  out  1  one-cycle completion pulse to the I-cache
- ic_rdata  out  LINE_W  line returned to the I-cache
- dc_req  in  1  D-cache request
- dc_we  in  1  D-cache request is a line write
- dc_addr  in  PADDR_W  D-cache line byte address, 16-byte aligned
- dc_wdata  in  LINE_W  D-cache write line
- dc_ack  out  1  one-cycle completion pulse to the D-cache
- dc_rdata  out  LINE_W  line returned to the D-cache
- data_requested  out  20  RAM read word index = latched_addr>>2
- where_to_write  out  20  RAM write line index = latched_addr>>4
- data_to_write  out  LINE_W  RAM write data
- write_to_mem  out  1  RAM write enable
- data_returned  in  LINE_W  RAM read data
- busy  out  1  high in BUSY and RESP

Behaviour:
- Reset (sync, active-high) drives all outputs to 0 and state to IDLE; last_grant = IC; cnt = 0.
- Reset mid-transaction aborts with no ack. write_to_mem is 0 from the next posedge.
- State machine: IDLE -> BUSY -> RESP -> IDLE.
- IDLE, accept edge E0 with any req high:
  - Choose the winner, latch addr/we/wdata and the grant id, set cnt = MEM_LATENCY-1, go BUSY.
- Arbitration:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_grant (round-robin).
  - last_grant updates on every grant.
- BUSY:
  - RAM address outputs are driven from the latched registers, stable for the whole state.
  - write_to_mem = latched dc_we; repeated RAM writes of the same line are idempotent.
  - Each posedge with cnt != 0 decrements cnt.
  - At the posedge with cnt == 0 (edge E0+MEM_LATENCY), for a read: capture data_returned into the granted requester's rdata register. Then assert that requester's ack and go RESP.
- Write completion: rdata registers are unchanged; dc_ack is still pulsed.
- RESP:
  - ack is high for exactly this one cycle; write_to_mem = 0.
  - Requests are ignored here; the next posedge returns to IDLE.
  - Earliest next accept is edge E0+MEM_LATENCY+2.
- Requester contract:
  - Hold req, addr, we and wdata stable from assertion until ack.
  - Drop req on the edge ending the ack cycle; a req still high in IDLE is a new request.
- Loser of a conflict waits; it is granted on the next IDLE accept. No starvation.
- ic_rdata and dc_rdata hold their values until the next read completion for that port.
- addr bits [3:0] are ignored.

Optional Feature:
- Macro MEM_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority; dc_req always wins a conflict and last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, BUSY, RESP}
  - req_id_t enum {IC, DC}
  - constants LINE_W, PADDR_W, WORDS_PER_LINE = 4
- Sub-module mem_arb_rr: 2-way arbiter holding last_grant.
  - Inputs: ic_req, dc_req, grant_en.
  - Output: grant id.
  - Encapsulates the MEM_ARB_DCACHE_PRIO_EN switch.

Test Plan:
- I-cache read, MEM_LATENCY=5, RAM preloaded: ic_req, ic_addr=0x00000 at E0.
  - ic_ack high only in the cycle after E5.
  - ic_rdata = {mem[3],mem[2],mem[1],mem[0]}.
  - data_requested = 0.
- D-cache write: dc_we=1, dc_addr=0x00400, dc_wdata=128'h4444_3333_2222_1111.
  - write_to_mem high exactly 5 cycles, where_to_write=0x40.
  - Following dc read of 0x00400 returns the same line in dc_rdata.
- Simultaneous ic_req and dc_req after reset:
  - dc granted first, ic second.
  - Repeated conflicts alternate DC, IC, DC.
  - With MEM_ARB_DCACHE_PRIO_EN: DC always granted.
- Back-to-back: requester holds req until ack and re-raises it immediately.
  - Second accept at E7, not earlier.
  - No duplicate ack.
- Reset asserted during BUSY of a write:
  - write_to_mem=0 and busy=0 after that edge; no ack.
  - After reset, a request completes normally.
- MEM_LATENCY=1: read accepted at E0 gives ack in the cycle after E1 with correct data, sampled after the RAM negedge.
